// File: rtl/nexys4_spi_pkg.sv
// Shared definitions for the Nexys4 seven-segment display SPI link:
// FSM states, word geometry and command-field layout.
package nexys4_spi_pkg;

    localparam int SPI_WORD_W = 16;

    localparam int CMD_MSB  = 15;
    localparam int CMD_LSB  = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_CTRL  = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LOW,
        ST_HIGH,
        ST_TRAIL,
        ST_GAP
    } spi_state_t;

    function automatic logic [SPI_WORD_W-1:0] pack_cmd(input logic [3:0] cmd,
                                                       input logic [3:0] addr,
                                                       input logic [7:0] data);
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a
// load of N-1 yields a phase of exactly N cycles.
module spi_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             block_clk_i,
    input  logic             rst_low_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge block_clk_i) begin
        if (!rst_low_i)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_display_master.sv
// SPI master for the display block: shifts one WORD_W command word out on
// MOSI (MSB first) per SS frame and collects MISO into rx_word_o.
module spi_display_master
    import nexys4_spi_pkg::*;
#(
    parameter int WORD_W     = SPI_WORD_W,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              block_clk_i,
    input  logic              rst_low_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [WORD_W-1:0] rx_word_o,
    output logic              spi_sclk_o,
    output logic              spi_ss_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);

    localparam int MAX_PH = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_PH);
    localparam int BIT_W  = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    spi_state_t        state, state_nxt;
    logic [WORD_W-1:0] tx_sreg, tx_nxt;
    logic [WORD_W-1:0] rx_sreg, rx_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;

    logic              ss_nxt, sclk_nxt, mosi_nxt, ready_nxt, done_nxt;
    logic [WORD_W-1:0] rx_word_nxt;

    logic              ph_tc, ph_load;
    logic [CNT_W-1:0]  ph_val;

    // Timer is held loaded in IDLE so LEAD starts with a full phase.
    assign ph_load = (state == ST_IDLE) || ph_tc;
    assign ph_val  = (state_nxt == ST_GAP) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(CLK_DIV - 1);

    spi_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .block_clk_i (block_clk_i),
        .rst_low_i   (rst_low_i),
        .load        (ph_load),
        .load_val    (ph_val),
        .tc          (ph_tc)
    );

    always_ff @(posedge block_clk_i) begin
        if (!rst_low_i) begin
            state   <= ST_IDLE;
            tx_sreg <= '0;
            rx_sreg <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tx_sreg <= tx_nxt;
            rx_sreg <= rx_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_sreg;
        rx_nxt    = rx_sreg;
        bit_nxt   = bit_cnt;
        unique case (state)
            ST_IDLE: begin
                if (valid_i && ready_o) begin
                    state_nxt = ST_LEAD;
                    tx_nxt    = word_i;
                    bit_nxt   = '0;
                end
            end
            ST_LEAD:  if (ph_tc) state_nxt = ST_LOW;
            ST_LOW:   if (ph_tc) state_nxt = ST_HIGH;
            ST_HIGH: begin
                if (ph_tc) begin
                    rx_nxt = {rx_sreg[WORD_W-2:0], spi_miso_i};
                    tx_nxt = {tx_sreg[WORD_W-2:0], 1'b0};
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_TRAIL;
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        state_nxt = ST_LOW;
                    end
                end
            end
            ST_TRAIL: if (ph_tc) state_nxt = ST_GAP;
            ST_GAP:   if (ph_tc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pin values are computed from the upcoming state and registered, so
    // every output changes exactly on the edge that enters a phase.
    always_comb begin
        ss_nxt      = !((state_nxt == ST_IDLE) || (state_nxt == ST_GAP));
        ss_nxt      = !ss_nxt;
        sclk_nxt    = (state_nxt != ST_LOW);
        ready_nxt   = (state_nxt == ST_IDLE);
        done_nxt    = (state_nxt == ST_GAP) && (state != ST_GAP);
        rx_word_nxt = done_nxt ? rx_sreg : rx_word_o;
        unique case (state_nxt)
            ST_LOW:           mosi_nxt = tx_nxt[WORD_W-1];
            ST_HIGH, ST_TRAIL: mosi_nxt = spi_mosi_o;
            default:          mosi_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge block_clk_i) begin
        if (!rst_low_i) begin
            spi_ss_o   <= 1'b1;
            spi_sclk_o <= 1'b1;
            spi_mosi_o <= 1'b1;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            rx_word_o  <= '0;
        end else begin
            spi_ss_o   <= ss_nxt;
            spi_sclk_o <= sclk_nxt;
            spi_mosi_o <= mosi_nxt;
            ready_o    <= ready_nxt;
            done_o     <= done_nxt;
            rx_word_o  <= rx_word_nxt;
        end
    end

endmodule

// File: tb/tb_spi_display_master.sv
// Directed bench for spi_display_master: a passive SPI monitor decodes each
// SS frame, and a linear step sequence checks it against hand-derived values.
module tb_spi_display_master;
    import nexys4_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] word;
    logic        valid;
    logic        loopback;
    logic        ready, done, sclk, ss, mosi, miso;
    logic [15:0] rx_word;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : 1'b1;

    spi_display_master #(.WORD_W(16), .CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .block_clk_i (clk),
        .rst_low_i   (rst_n),
        .word_i      (word),
        .valid_i     (valid),
        .ready_o     (ready),
        .done_o      (done),
        .rx_word_o   (rx_word),
        .spi_sclk_o  (sclk),
        .spi_ss_o    (ss),
        .spi_mosi_o  (mosi),
        .spi_miso_i  (miso)
    );

    // SPI slave-side monitor, sampled on the falling edge.
    logic        prev_ss = 1'b1, prev_sclk = 1'b1;
    logic [15:0] mon_word = '0, last_word = '0, prev_word = '0;
    int          mon_bits = 0, last_bits = 0, low_cnt = 0, last_low = 0;
    int          high_run = 0, last_high = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (prev_ss && !ss) begin
            last_high <= high_run;
            mon_bits  <= 0;
            mon_word  <= '0;
            low_cnt   <= 1;
        end else if (!ss) begin
            low_cnt <= low_cnt + 1;
        end
        if (!ss && !prev_ss && !prev_sclk && sclk) begin
            mon_word <= {mon_word[14:0], mosi};
            mon_bits <= mon_bits + 1;
        end
        if (!prev_ss && ss) begin
            prev_word <= last_word;
            last_word <= mon_word;
            last_bits <= mon_bits;
            last_low  <= low_cnt;
            high_run  <= 1;
        end else if (ss) begin
            high_run <= high_run + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        prev_ss   <= ss;
        prev_sclk <= sclk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] w);
        wait_ready();
        word  = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(output bit busy_ready);
        int n = 0;
        busy_ready = 1'b0;
        while (!done && n < 2000) begin
            if (ready) busy_ready = 1'b1;
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles_to_ready(output int k);
        k = 0;
        while (!ready && k < 100) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit busy;
        int k, base;

        rst_n    = 1'b0;
        word     = '0;
        valid    = 1'b0;
        loopback = 1'b0;
        repeat (3) tick();
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rx_word), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_ss", 32'(ss), 32'd1);

        // Single word, MISO idle high
        base = done_cnt;
        send(16'h11AA);
        chk("accept_ss_low", 32'(ss), 32'd0);
        chk("accept_ready_low", 32'(ready), 32'd0);
        wait_done(busy);
        chk("single_rx_idle_miso", 32'(rx_word), 32'hFFFF);
        chk("single_ss_at_done", 32'(ss), 32'd1);
        chk("single_word", 32'(last_word), 32'h11AA);
        chk("single_bits", 32'(last_bits), 32'd16);
        chk("single_ss_low_cycles", 32'(last_low), 32'd136);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        cycles_to_ready(k);
        chk("done_to_ready", 32'(k + 1), 32'd8);
        chk("single_done_count", 32'(done_cnt - base), 32'd1);

        // Loopback
        loopback = 1'b1;
        send(pack_cmd(CMD_WRITE, 4'h2, 8'h34));
        wait_done(busy);
        chk("loop_rx_1234", 32'(rx_word), 32'h1234);
        send(16'h0000);
        repeat (70) tick();
        chk("loop_rx_held", 32'(rx_word), 32'h1234);
        wait_done(busy);
        chk("loop_rx_0000", 32'(rx_word), 32'h0000);
        loopback = 1'b0;

        // Back-to-back with valid held high
        wait_ready();
        word  = 16'h12BB;
        valid = 1'b1;
        tick();
        word = 16'h13CC;
        wait_done(busy);
        wait_ready();
        tick();
        valid = 1'b0;
        wait_done(busy);
        chk("b2b_first", 32'(prev_word), 32'h12BB);
        chk("b2b_second", 32'(last_word), 32'h13CC);
        chk("b2b_ss_high_gap", 32'(last_high), 32'd9);

        // Busy ignore
        send(16'h2468);
        repeat (20) tick();
        word  = 16'hFFFF;
        wait_done(busy);
        chk("busy_ready_low", 32'(busy), 32'd0);
        chk("busy_ready_at_done", 32'(ready), 32'd0);
        chk("busy_word", 32'(last_word), 32'h2468);
        tick();
        cycles_to_ready(k);
        chk("busy_gap_to_ready", 32'(k + 1), 32'd8);

        // Reset mid-word after 5th SCLK rise
        base = done_cnt;
        send(pack_cmd(CMD_CTRL, 4'hA, 8'hA5));
        k = 0;
        while (mon_bits != 5 && k < 200) begin
            tick();
            k++;
        end
        chk("abort_reach_5_bits", 32'(mon_bits), 32'd5);
        rst_n = 1'b0;
        tick();
        chk("abort_ss", 32'(ss), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd1);
        chk("abort_mosi", 32'(mosi), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        chk("abort_partial_bits", 32'(last_bits), 32'd5);
        send(16'h04FF);
        wait_done(busy);
        chk("after_abort_word", 32'(last_word), 32'h04FF);
        chk("after_abort_bits", 32'(last_bits), 32'd16);
        chk("after_abort_done", 32'(done_cnt - base), 32'd1);
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
